cover_toggle_collector: RTL and testbench

- Consumer end of the toggle-coverage interface: takes the per-cycle `valid` hit vector that toggle cover points drive.
- Records each point once (sticky bitmap) and serializes newly hit points as absolute cover indices on a valid/ready stream.
- Synthesizable counterpart to simulation-only index reporting; used in formal/FPGA builds where DPI is unavailable.
- Indices are global: COVER_INDEX + bit position.

---
 rtl/cover_toggle_pkg.sv | 12 +
 rtl/cover_prio_enc.sv | 24 ++
 rtl/cover_toggle_collector.sv | 150 +++++++++++++++
 tb/tb_cover_toggle_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_toggle_pkg.sv
// Shared types and default constants for the toggle-coverage collector.
package cover_toggle_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   localparam int DEF_IDX_W       = 64;
   localparam int DEF_COVER_TOTAL = 8065;

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit of req and whether any bit is set.
module cover_prio_enc #(
   parameter int WIDTH = 4,
   parameter int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = SEL_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-coverage collector that streams each newly hit point as a
// global cover index. Optional re-report input `flush` under COVER_TOGGLE_FLUSH_EN.
//
// state | meaning
// IDLE  | nothing offered; out_valid low
// OFFER | out_index holds COVER_INDEX + sel; waiting for out_ready
module cover_toggle_collector
   import cover_toggle_pkg::*;
#(
   parameter  int WIDTH       = 4,
   parameter  int COVER_INDEX = 0,
   parameter  int COVER_TOTAL = DEF_COVER_TOTAL,
   parameter  int IDX_W       = DEF_IDX_W,
   localparam int CNT_W       = $clog2(WIDTH + 1),
   localparam int SEL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] valid,
   input  logic             clear,
`ifdef COVER_TOGGLE_FLUSH_EN
   input  logic             flush,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic [WIDTH-1:0] hit_map,
   output logic [CNT_W-1:0] hit_count,
   output logic             all_hit
);

   generate
      if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
         $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
      end
   endgenerate

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  hit_map_q, hit_map_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0]  hit_count_q, hit_count_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;

   logic              accept;
   logic [WIDTH-1:0]  acc_mask;
   logic [WIDTH-1:0]  new_hits;
   logic [WIDTH-1:0]  flush_bits;
   logic [WIDTH-1:0]  pending_nx;
   logic [CNT_W-1:0]  new_cnt;
   logic [SEL_W-1:0]  nxt_sel;
   logic              nxt_any;

   assign accept   = (state_q == OFFER) && out_ready;
   assign acc_mask = accept ? (WIDTH'(1) << sel_q) : '0;
   assign new_hits = valid & ~hit_map_q;

`ifdef COVER_TOGGLE_FLUSH_EN
   assign flush_bits = flush ? hit_map_q : '0;
`else
   assign flush_bits = '0;
`endif

   // Pending set as it will be after this edge (ignoring clear); the next
   // offer is chosen from it so a fresh hit can be offered the following cycle.
   assign pending_nx = (pending_q & ~acc_mask) | new_hits | flush_bits;

   always_comb begin
      new_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         new_cnt = new_cnt + CNT_W'(new_hits[i]);
      end
   end

   cover_prio_enc #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_prio_enc (
      .req (pending_nx),
      .idx (nxt_sel),
      .any (nxt_any)
   );

   always_comb begin
      state_d     = state_q;
      hit_map_d   = hit_map_q;
      pending_d   = pending_q;
      hit_count_d = hit_count_q;
      sel_d       = sel_q;
      out_index_d = out_index_q;

      if (clear) begin
         state_d     = IDLE;
         hit_map_d   = '0;
         pending_d   = '0;
         hit_count_d = '0;
      end else begin
         hit_map_d   = hit_map_q | valid;
         hit_count_d = hit_count_q + new_cnt;
         pending_d   = pending_nx;

         // A stalled offer is never replaced; only IDLE or an accept reloads sel.
         case (state_q)
            IDLE: begin
               if (nxt_any) begin
                  state_d     = OFFER;
                  sel_d       = nxt_sel;
                  out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(nxt_sel);
               end
            end
            OFFER: begin
               if (accept) begin
                  if (nxt_any) begin
                     sel_d       = nxt_sel;
                     out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(nxt_sel);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         hit_map_q   <= '0;
         pending_q   <= '0;
         hit_count_q <= '0;
         sel_q       <= '0;
         out_index_q <= '0;
      end else begin
         state_q     <= state_d;
         hit_map_q   <= hit_map_d;
         pending_q   <= pending_d;
         hit_count_q <= hit_count_d;
         sel_q       <= sel_d;
         out_index_q <= out_index_d;
      end
   end

   assign out_valid = (state_q == OFFER);
   assign out_index = out_index_q;
   assign hit_map   = hit_map_q;
   assign hit_count = hit_count_q;
   assign all_hit   = (hit_count_q == CNT_W'(WIDTH));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector (WIDTH=4, COVER_INDEX=100): directed
// scenarios plus randomized traffic against a set-based reference model.
module tb_cover_toggle_collector;

   localparam int W    = 4;
   localparam int BASE = 100;

   logic        clock;
   logic        reset;
   logic [3:0]  valid;
   logic        clear;
`ifdef COVER_TOGGLE_FLUSH_EN
   logic        flush;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_index;
   logic [3:0]  hit_map;
   logic [2:0]  hit_count;
   logic        all_hit;

   int n_checks;
   int n_fail;
   int delivered[$];

   // Reference model: sets of hit and pending points, plus the offered point.
   bit m_hit[W];
   bit m_pend[W];
   bit m_offer;
   int m_held;
   int m_cnt;

   cover_toggle_collector #(
      .WIDTH       (4),
      .COVER_INDEX (BASE),
      .COVER_TOTAL (8065),
      .IDX_W       (64)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid),
      .clear     (clear),
`ifdef COVER_TOGGLE_FLUSH_EN
      .flush     (flush),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .hit_map   (hit_map),
      .hit_count (hit_count),
      .all_hit   (all_hit)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      for (int i = 0; i < W; i++) begin
         m_hit[i]  = 1'b0;
         m_pend[i] = 1'b0;
      end
      m_offer = 1'b0;
      m_held  = 0;
      m_cnt   = 0;
   endtask

   function automatic logic [3:0] model_map();
      logic [3:0] m;
      for (int i = 0; i < W; i++) m[i] = m_hit[i];
      return m;
   endfunction

   // Drive one cycle at the negedge, log handshakes, advance the model at the
   // posedge and return #1 after it.
   task automatic step(input logic [3:0] v, input logic clr, input logic rdy, input logic fl);
      bit acc;
      @(negedge clock);
      valid     = v;
      clear     = clr;
      out_ready = rdy;
`ifdef COVER_TOGGLE_FLUSH_EN
      flush     = fl;
`endif
      if (out_valid && rdy) delivered.push_back(int'(out_index));
      @(posedge clock);
      if (clr) begin
         model_reset();
      end else begin
         acc = m_offer && rdy;
         if (acc) m_pend[m_held] = 1'b0;
         for (int i = 0; i < W; i++) begin
            if (fl && m_hit[i]) m_pend[i] = 1'b1;
            if (v[i] && !m_hit[i]) begin
               m_hit[i]  = 1'b1;
               m_pend[i] = 1'b1;
               m_cnt++;
            end
         end
         if (!m_offer || acc) begin
            m_offer = 1'b0;
            for (int i = W - 1; i >= 0; i--) begin
               if (m_pend[i]) begin
                  m_offer = 1'b1;
                  m_held  = i;
               end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; valid = '0; clear = 1'b0; out_ready = 1'b0;
`ifdef COVER_TOGGLE_FLUSH_EN
      flush = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      n_checks++; if (out_index !== 64'd0) begin n_fail++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
      n_checks++; if (hit_map !== 4'b0000) begin n_fail++; $display("FAIL reset_hit_map: got %b expected 0000", hit_map); end
      n_checks++; if (hit_count !== 3'd0) begin n_fail++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
      n_checks++; if (all_hit !== 1'b0) begin n_fail++; $display("FAIL reset_all_hit: got %0b expected 0", all_hit); end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      delivered.delete();
      step(4'b0101, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd100) begin n_fail++; $display("FAIL basic_first: got v=%0b idx=%0d expected v=1 idx=100", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd102) begin n_fail++; $display("FAIL basic_second: got v=%0b idx=%0d expected v=1 idx=102", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0b expected 0", out_valid); end
      n_checks++; if (hit_count !== 3'd2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", hit_count); end
      n_checks++; if (hit_map !== 4'b0101) begin n_fail++; $display("FAIL basic_map: got %b expected 0101", hit_map); end
      n_checks++; if (delivered.size() != 2 || delivered[0] != 100 || delivered[1] != 102) begin n_fail++; $display("FAIL basic_stream: got %0d reports expected 100,102", delivered.size()); end
   endtask

   task automatic test_stall();
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      delivered.delete();
      step(4'b0100, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd102) begin n_fail++; $display("FAIL stall_offer: got v=%0b idx=%0d expected v=1 idx=102", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_index !== 64'd102) begin n_fail++; $display("FAIL stall_no_preempt: got %0d expected 102", out_index); end
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd102) begin n_fail++; $display("FAIL stall_hold: got v=%0b idx=%0d expected v=1 idx=102", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd100) begin n_fail++; $display("FAIL stall_next: got v=%0b idx=%0d expected v=1 idx=100", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %0b expected 0", out_valid); end
      n_checks++; if (delivered.size() != 2 || delivered[0] != 102 || delivered[1] != 100) begin n_fail++; $display("FAIL stall_stream: got %0d reports expected 102,100", delivered.size()); end
   endtask

   task automatic test_repeat();
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      delivered.delete();
      step(4'b0010, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd101) begin n_fail++; $display("FAIL repeat_first: got v=%0b idx=%0d expected v=1 idx=101", out_valid, out_index); end
      step(4'b0010, 1'b0, 1'b1, 1'b0);
      step(4'b0010, 1'b0, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (delivered.size() != 1 || delivered[0] != 101) begin n_fail++; $display("FAIL repeat_stream: got %0d reports expected one (101)", delivered.size()); end
      n_checks++; if (hit_count !== 3'd1) begin n_fail++; $display("FAIL repeat_count: got %0d expected 1", hit_count); end
   endtask

   task automatic test_clear();
      step(4'b1111, 1'b1, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0 || hit_count !== 3'd0 || hit_map !== 4'b0000) begin n_fail++; $display("FAIL clear_wins: got v=%0b cnt=%0d map=%b expected 0,0,0000", out_valid, hit_count, hit_map); end
      delivered.delete();
      step(4'b1000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd103) begin n_fail++; $display("FAIL clear_after: got v=%0b idx=%0d expected v=1 idx=103", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (all_hit !== 1'b0 || hit_count !== 3'd1) begin n_fail++; $display("FAIL clear_count: got all=%0b cnt=%0d expected 0,1", all_hit, hit_count); end
      n_checks++; if (delivered.size() != 1 || delivered[0] != 103) begin n_fail++; $display("FAIL clear_stream: got %0d reports expected one (103)", delivered.size()); end
   endtask

   task automatic test_mid_reset();
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd102) begin n_fail++; $display("FAIL mreset_offer: got v=%0b idx=%0d expected v=1 idx=102", out_valid, out_index); end
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mreset_async: got %0b expected 0", out_valid); end
      model_reset();
      @(negedge clock);
      valid = '0;
      reset = 1'b1;
      delivered.delete();
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0 || hit_map !== 4'b0000) begin n_fail++; $display("FAIL mreset_after: got v=%0b map=%b expected 0,0000", out_valid, hit_map); end
      n_checks++; if (delivered.size() != 0) begin n_fail++; $display("FAIL mreset_residual: got %0d reports expected 0", delivered.size()); end
   endtask

`ifdef COVER_TOGGLE_FLUSH_EN
   task automatic test_flush();
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      step(4'b1001, 1'b0, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      delivered.delete();
      step(4'b0000, 1'b0, 1'b1, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd100) begin n_fail++; $display("FAIL flush_first: got v=%0b idx=%0d expected v=1 idx=100", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_index !== 64'd103) begin n_fail++; $display("FAIL flush_second: got v=%0b idx=%0d expected v=1 idx=103", out_valid, out_index); end
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0 || hit_count !== 3'd2) begin n_fail++; $display("FAIL flush_end: got v=%0b cnt=%0d expected 0,2", out_valid, hit_count); end
      n_checks++; if (delivered.size() != 2) begin n_fail++; $display("FAIL flush_stream: got %0d reports expected 2", delivered.size()); end
   endtask
`endif

   task automatic test_random();
      logic [3:0] v;
      logic       clr, rdy, fl;
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 600; c++) begin
         v   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         clr = ($urandom_range(0, 59) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         fl  = 1'b0;
`ifdef COVER_TOGGLE_FLUSH_EN
         fl  = ($urandom_range(0, 29) == 0);
`endif
         step(v, clr, rdy, fl);
         n_checks++; if (out_valid !== m_offer) begin n_fail++; $display("FAIL rand_valid c=%0d: got %0b expected %0b", c, out_valid, m_offer); end
         if (m_offer) begin
            n_checks++; if (out_index !== 64'(BASE + m_held)) begin n_fail++; $display("FAIL rand_index c=%0d: got %0d expected %0d", c, out_index, BASE + m_held); end
         end
         n_checks++; if (hit_map !== model_map()) begin n_fail++; $display("FAIL rand_map c=%0d: got %b expected %b", c, hit_map, model_map()); end
         n_checks++; if (hit_count !== 3'(m_cnt)) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, hit_count, m_cnt); end
         n_checks++; if (all_hit !== (m_cnt == W)) begin n_fail++; $display("FAIL rand_all_hit c=%0d: got %0b expected %0b", c, all_hit, (m_cnt == W)); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic();
      test_stall();
      test_repeat();
      test_clear();
      test_mid_reset();
`ifdef COVER_TOGGLE_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
